// File: rtl/att_sched_pkg.sv
// Shared types and constants for the attitude update scheduler.
// Holds the FSM encoding, default timing parameters and the saturating-counter helper.
package att_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IMU_RD   = 3'd1,
    ACC_CALC = 3'd2,
    FILTER   = 3'd3,
    SETTLE   = 3'd4,
    PUBLISH  = 3'd5
  } att_state_e;

  localparam int DEF_PERIOD_CYC  = 100000;
  localparam int DEF_TIMEOUT_CYC = 5000;
  localparam int DEF_FILTER_LAT  = 1;

  localparam int SEQ_W  = 16;
  localparam int STAT_W = 8;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/att_update_sched_if.sv
// Bundle between the scheduler and the IMU reader, accel-angle unit, cmp_filter and PID stage.
// Also carries the status counters, fault flags and the FSM state for observation.
interface att_update_sched_if;
  import att_sched_pkg::*;

  // imu_rd_req is a level held until a one-cycle imu_rd_done; acc_start, acc_done,
  // cmp_filter_en and att_valid are one-cycle strobes with no backpressure.
  // A done pulse that arrives outside its wait state is dropped.
  logic              sched_en;
  logic              fault_clr;
  logic              imu_rd_req;
  logic              imu_rd_done;
  logic              acc_start;
  logic              acc_done;
  logic              cmp_filter_en;
  logic              att_valid;
  logic              busy;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [STAT_W-1:0] ovr_cnt;
  logic [STAT_W-1:0] err_cnt;
  logic              imu_fault;
  logic              acc_fault;
  att_state_e        state;

  modport master (
    input  sched_en, fault_clr, imu_rd_done, acc_done,
    output imu_rd_req, acc_start, cmp_filter_en, att_valid, busy,
           seq_cnt, ovr_cnt, err_cnt, imu_fault, acc_fault, state
  );

  modport slave (
    output sched_en, fault_clr, imu_rd_done, acc_done,
    input  imu_rd_req, acc_start, cmp_filter_en, att_valid, busy,
           seq_cnt, ovr_cnt, err_cnt, imu_fault, acc_fault, state
  );

endinterface

// File: rtl/att_period_timer.sv
// Free-running period counter that emits a one-cycle tick every PERIOD_CYC cycles.
// The count is parked at zero while disabled so a fresh enable always waits a full period.
module att_period_timer #(
  parameter int PERIOD_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/att_update_sched.sv
// Attitude update sequencer: tick -> IMU read -> accel angles -> filter enable -> settle -> publish.
// Tracks timeouts and dropped ticks with sticky faults and saturating counters.
module att_update_sched
  import att_sched_pkg::*;
#(
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FILTER_LAT  = DEF_FILTER_LAT
) (
  input logic                clk,
  input logic                rst,
  att_update_sched_if.master bus
);

  localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam int            LW       = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(FILTER_LAT - 1);

  att_state_e        state;
  att_state_e        state_n;
  logic              tick;
  logic              to_hit;
  logic              imu_to;
  logic              acc_to;
  logic [TW-1:0]     to_cnt;
  logic [LW-1:0]     lat_cnt;
  logic              acc_start_q;
  logic              att_valid_q;
  logic              imu_fault_q;
  logic              acc_fault_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [STAT_W-1:0] ovr_q;
  logic [STAT_W-1:0] err_q;

  att_period_timer #(
    .PERIOD_CYC(PERIOD_CYC)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (bus.sched_en),
    .tick(tick)
  );

  assign to_hit = (to_cnt == TO_LAST);

  // A done seen on the limit cycle is checked first, so it beats the timeout.
  always_comb begin
    state_n           = state;
    imu_to            = 1'b0;
    acc_to            = 1'b0;
    bus.imu_rd_req    = 1'b0;
    bus.cmp_filter_en = 1'b0;
    bus.busy          = 1'b0;
    if (!bus.sched_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:     if (tick) state_n = IMU_RD;
        IMU_RD: begin
          if (bus.imu_rd_done) begin
            state_n = ACC_CALC;
          end else if (to_hit) begin
            state_n = IDLE;
            imu_to  = 1'b1;
          end
        end
        ACC_CALC: begin
          if (bus.acc_done) begin
            state_n = FILTER;
          end else if (to_hit) begin
            state_n = IDLE;
            acc_to  = 1'b1;
          end
        end
        FILTER:   state_n = SETTLE;
        SETTLE:   if (lat_cnt == LAT_LAST) state_n = PUBLISH;
        PUBLISH:  state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
    bus.imu_rd_req    = (state == IMU_RD);
    bus.cmp_filter_en = (state == FILTER);
    bus.busy          = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      lat_cnt     <= '0;
      acc_start_q <= 1'b0;
      att_valid_q <= 1'b0;
      imu_fault_q <= 1'b0;
      acc_fault_q <= 1'b0;
      seq_q       <= '0;
      ovr_q       <= '0;
      err_q       <= '0;
    end else begin
      state <= state_n;

      // Restart the wait budget on every state change; only the two wait states count.
      if (state_n != state) begin
        to_cnt <= '0;
      end else if (state == IMU_RD || state == ACC_CALC) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state == SETTLE && state_n == SETTLE) begin
        lat_cnt <= lat_cnt + 1'b1;
      end else begin
        lat_cnt <= '0;
      end

      acc_start_q <= (state == IMU_RD) && (state_n == ACC_CALC);
      att_valid_q <= (state == PUBLISH) && bus.sched_en;

      if (state == PUBLISH && bus.sched_en) seq_q <= seq_q + 1'b1;
      if (tick && state != IDLE)            ovr_q <= sat_inc(ovr_q);
      if (imu_to || acc_to)                 err_q <= sat_inc(err_q);

      if (imu_to)             imu_fault_q <= 1'b1;
      else if (bus.fault_clr) imu_fault_q <= 1'b0;
      if (acc_to)             acc_fault_q <= 1'b1;
      else if (bus.fault_clr) acc_fault_q <= 1'b0;
    end
  end

  assign bus.acc_start = acc_start_q;
  assign bus.att_valid = att_valid_q;
  assign bus.seq_cnt   = seq_q;
  assign bus.ovr_cnt   = ovr_q;
  assign bus.err_cnt   = err_q;
  assign bus.imu_fault = imu_fault_q;
  assign bus.acc_fault = acc_fault_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_att_update_sched.sv
// Directed bench for att_update_sched with PERIOD_CYC=20, FILTER_LAT=1 and two timeout settings.
// Drives the IMU/accel done pulses like the neighbouring units would and checks hand-computed results.
module tb_att_update_sched;
  import att_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  att_update_sched_if ifa ();
  att_update_sched_if ifb ();

  att_update_sched #(.PERIOD_CYC(20), .TIMEOUT_CYC(8), .FILTER_LAT(1)) dut (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  att_update_sched #(.PERIOD_CYC(20), .TIMEOUT_CYC(30), .FILTER_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (samples 1 time unit after the active edge) ----------------
  int cyc = 0;
  int n_as = 0, n_cfe = 0, n_av = 0, n_req = 0, nb_av = 0;
  int t_cfe = 0, t_av = 0, t_av_prev = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (ifa.acc_start === 1'b1)     n_as++;
    if (ifa.imu_rd_req === 1'b1)    n_req++;
    if (ifa.cmp_filter_en === 1'b1) begin n_cfe++; t_cfe = cyc; end
    if (ifa.att_valid === 1'b1) begin
      n_av++;
      t_av_prev = t_av;
      t_av      = cyc;
      obs_q.push_back(ifa.seq_cnt);
    end
    if (ifb.att_valid === 1'b1)     nb_av++;
  end

  // ---------------- driver tasks ----------------
  function automatic bit sig_of(input int sel);
    case (sel)
      0:       return ifa.imu_rd_req === 1'b1;
      1:       return ifa.acc_start === 1'b1;
      3:       return ifa.att_valid === 1'b1;
      5:       return ifa.imu_rd_req === 1'b0;
      10:      return ifb.imu_rd_req === 1'b1;
      11:      return ifb.acc_start === 1'b1;
      12:      return ifb.att_valid === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_a(input int sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (sig_of(sel)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Answers one sequence on the main DUT; a negative delay means that done is never sent.
  task automatic run_seq(input int imu_dly, input int acc_dly, output bit ok);
    bit w;
    wait_a(0, 45, w);
    ok = w;
    if (!w || imu_dly < 0) return;
    repeat (imu_dly) @(negedge clk);
    ifa.imu_rd_done = 1'b1;
    @(negedge clk);
    ifa.imu_rd_done = 1'b0;
    wait_a(1, 4, w);
    ok = w;
    if (!w || acc_dly < 0) return;
    repeat (acc_dly) @(negedge clk);
    ifa.acc_done = 1'b1;
    @(negedge clk);
    ifa.acc_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time-limit expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    bit ok2;
    int s_as, s_cfe, s_av, s_req, s_bav;

    rst = 1'b1;
    ifa.sched_en = 1'b0; ifa.fault_clr = 1'b0; ifa.imu_rd_done = 1'b0; ifa.acc_done = 1'b0;
    ifb.sched_en = 1'b0; ifb.fault_clr = 1'b0; ifb.imu_rd_done = 1'b0; ifb.acc_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req",   32'(ifa.imu_rd_req), 0);
    chk("rst_as",    32'(ifa.acc_start), 0);
    chk("rst_cfe",   32'(ifa.cmp_filter_en), 0);
    chk("rst_av",    32'(ifa.att_valid), 0);
    chk("rst_busy",  32'(ifa.busy), 0);
    chk("rst_seq",   32'(ifa.seq_cnt), 0);
    chk("rst_ovr",   32'(ifa.ovr_cnt), 0);
    chk("rst_err",   32'(ifa.err_cnt), 0);
    chk("rst_ifault", 32'(ifa.imu_fault), 0);
    chk("rst_afault", 32'(ifa.acc_fault), 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal: three full sequences, one period apart
    ifa.sched_en = 1'b1;
    s_as = n_as; s_cfe = n_cfe; s_av = n_av;
    run_seq(3, 2, ok);  chk("nom1_hs", 32'(ok), 1);
    wait_a(3, 10, ok);  chk("nom1_av", 32'(ok), 1);
    exp_q.push_back(16'd1);
    chk("nom1_as_cnt",  n_as - s_as, 1);
    chk("nom1_cfe_cnt", n_cfe - s_cfe, 1);
    chk("nom1_lat",     t_av - t_cfe, 3);
    chk("nom1_seq",     32'(ifa.seq_cnt), 1);
    for (int k = 2; k <= 3; k++) begin
      run_seq(3, 2, ok); wait_a(3, 10, ok2);
      chk("nom_hs", 32'(ok & ok2), 1);
      exp_q.push_back(16'(k));
    end
    chk("nom3_seq",     32'(ifa.seq_cnt), 3);
    chk("nom3_av_cnt",  n_av - s_av, 3);
    chk("nom3_spacing", t_av - t_av_prev, 20);
    chk("nom3_ovr",     32'(ifa.ovr_cnt), 0);

    // IMU timeout: request held for 8 cycles, then a fresh sequence on the next tick
    s_req = n_req; s_cfe = n_cfe;
    run_seq(-1, -1, ok); chk("imuto_req_seen", 32'(ok), 1);
    wait_a(5, 20, ok);   chk("imuto_drop", 32'(ok), 1);
    chk("imuto_req_cyc", n_req - s_req, 8);
    chk("imuto_fault",   32'(ifa.imu_fault), 1);
    chk("imuto_err",     32'(ifa.err_cnt), 1);
    chk("imuto_cfe",     n_cfe - s_cfe, 0);
    chk("imuto_busy",    32'(ifa.busy), 0);
    run_seq(3, 2, ok); wait_a(3, 10, ok2);
    chk("imuto_next_hs", 32'(ok & ok2), 1);
    exp_q.push_back(16'd4);
    chk("imuto_next_seq", 32'(ifa.seq_cnt), 4);

    // acc_done on the limit cycle (count 7) still wins
    s_cfe = n_cfe;
    run_seq(3, 7, ok); wait_a(3, 10, ok2);
    chk("coll_hs", 32'(ok & ok2), 1);
    exp_q.push_back(16'd5);
    chk("coll_cfe",   n_cfe - s_cfe, 1);
    chk("coll_fault", 32'(ifa.acc_fault), 0);
    chk("coll_err",   32'(ifa.err_cnt), 1);

    // acc_done one cycle late: timeout, and the late pulse is ignored
    s_cfe = n_cfe; s_av = n_av;
    run_seq(3, 8, ok); chk("accto_hs", 32'(ok), 1);
    repeat (3) @(negedge clk);
    chk("accto_fault", 32'(ifa.acc_fault), 1);
    chk("accto_err",   32'(ifa.err_cnt), 2);
    chk("accto_cfe",   n_cfe - s_cfe, 0);
    chk("accto_av",    n_av - s_av, 0);
    chk("accto_busy",  32'(ifa.busy), 0);

    // Fault clear, then clear colliding with a new IMU timeout
    ifa.fault_clr = 1'b1; @(negedge clk); ifa.fault_clr = 1'b0;
    chk("fclr_ifault", 32'(ifa.imu_fault), 0);
    chk("fclr_afault", 32'(ifa.acc_fault), 0);
    run_seq(-1, -1, ok); chk("fclr_req_seen", 32'(ok), 1);
    repeat (7) @(negedge clk);
    ifa.fault_clr = 1'b1; @(negedge clk); ifa.fault_clr = 1'b0;
    chk("fclr_coll_ifault", 32'(ifa.imu_fault), 1);
    chk("fclr_coll_afault", 32'(ifa.acc_fault), 0);
    chk("fclr_coll_req",    32'(ifa.imu_rd_req), 0);
    chk("fclr_coll_err",    32'(ifa.err_cnt), 3);

    // Abort in ACC_CALC by dropping sched_en
    s_cfe = n_cfe; s_av = n_av;
    run_seq(3, -1, ok); chk("abort_hs", 32'(ok), 1);
    ifa.sched_en = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(ifa.busy), 0);
    chk("abort_req",  32'(ifa.imu_rd_req), 0);
    ifa.acc_done = 1'b1; @(negedge clk); ifa.acc_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_cfe",    n_cfe - s_cfe, 0);
    chk("abort_av",     n_av - s_av, 0);
    chk("abort_seq",    32'(ifa.seq_cnt), 5);
    chk("abort_err",    32'(ifa.err_cnt), 3);
    chk("abort_ifault", 32'(ifa.imu_fault), 1);
    chk("main_ovr",     32'(ifa.ovr_cnt), 0);

    // Reset pulse in the middle of IMU_RD
    ifa.sched_en = 1'b1;
    run_seq(-1, -1, ok); chk("mrst_req_seen", 32'(ok), 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("mrst_req",    32'(ifa.imu_rd_req), 0);
    chk("mrst_busy",   32'(ifa.busy), 0);
    chk("mrst_seq",    32'(ifa.seq_cnt), 0);
    chk("mrst_err",    32'(ifa.err_cnt), 0);
    chk("mrst_ifault", 32'(ifa.imu_fault), 0);
    ifa.sched_en = 1'b0;

    // Scoreboard: seq_cnt seen with every att_valid on the main DUT
    chk("sb_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk("sb_seq", 32'(obs_q[i]), 32'(exp_q[i]));
    end

    // Overrun on the TIMEOUT_CYC=30 instance: acc_done 25 cycles after acc_start
    ifb.sched_en = 1'b1;
    wait_a(10, 25, ok); chk("ovr_req_seen", 32'(ok), 1);
    repeat (3) @(negedge clk);
    ifb.imu_rd_done = 1'b1; @(negedge clk); ifb.imu_rd_done = 1'b0;
    wait_a(11, 4, ok); chk("ovr_as_seen", 32'(ok), 1);
    s_bav = nb_av;
    repeat (25) @(negedge clk);
    ifb.acc_done = 1'b1; @(negedge clk); ifb.acc_done = 1'b0;
    wait_a(12, 10, ok); chk("ovr_av_seen", 32'(ok), 1);
    ifb.sched_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovr_av_cnt", nb_av - s_bav, 1);
    chk("ovr_cnt1",   32'(ifb.ovr_cnt), 1);
    chk("ovr_seq",    32'(ifb.seq_cnt), 1);
    chk("ovr_err",    32'(ifb.err_cnt), 0);

    // Unanswered requests: one overrun and one timeout every 40 cycles, ~300 of each
    ifb.sched_en = 1'b1;
    repeat (12200) @(negedge clk);
    ifb.sched_en = 1'b0;
    @(negedge clk);
    chk("sat_ovr",    32'(ifb.ovr_cnt), 255);
    chk("sat_err",    32'(ifb.err_cnt), 255);
    chk("sat_ifault", 32'(ifb.imu_fault), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/att_update_sched.md
Name: att_update_sched

Overview:
Periodic scheduler for the attitude-estimation path. A fixed-period tick starts each sequence: IMU burst read, then accel-angle computation, then a one-cycle enable pulse to cmp_filter, then a filter-latency wait, then an att_valid strobe to the PID stage. Sits between the IMU reader / accel-angle unit and cmp_filter, and feeds the PID loop. Detects timeouts and overruns and keeps sticky fault flags and saturating counters.

Parameters:
PERIOD_CYC, 100000, clk cycles between update ticks (1 kHz at 100 MHz); must be >= 2.
TIMEOUT_CYC, 5000, maximum cycles to wait for imu_rd_done or acc_done.
FILTER_LAT, 1, cycles from cmp_filter_en to valid cmp_filter outputs; must be >= 1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sched_en  in  1  scheduler enable
fault_clr  in  1  one-cycle pulse; clears sticky faults
imu_rd_req  out  1  level request to the IMU reader
imu_rd_done  in  1  one-cycle pulse; IMU sample registers are updated
acc_start  out  1  one-cycle start pulse to the accel-angle unit
acc_done  in  1  one-cycle pulse; accel angles are valid
cmp_filter_en  out  1  one-cycle enable to cmp_filter
att_valid  out  1  one-cycle strobe; cur_pitch, cur_roll and cur_yaw are fresh
busy  out  1  high whenever state != IDLE
seq_cnt  out  16  completed sequences; wraps from 0xFFFF to 0
ovr_cnt  out  8  dropped ticks; saturates at 255
err_cnt  out  8  timeouts; saturates at 255
imu_fault  out  1  sticky; set by an IMU read timeout
acc_fault  out  1  sticky; set by an accel-angle timeout

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0 and the state goes to IDLE.
  - The period counter and the timeout counter clear.
  - rst has priority over every other input.
- Period timer:
  - Counts 0..PERIOD_CYC-1 while sched_en=1.
  - tick=1 in the cycle the count equals PERIOD_CYC-1; the count then wraps to 0.
  - While sched_en=0 the count is held at 0.
- FSM states: IDLE, IMU_RD, ACC_CALC, FILTER, SETTLE, PUBLISH.
  - IDLE: tick at cycle T gives IMU_RD at T+1 with imu_rd_req=1.
  - IMU_RD: imu_rd_req is held at 1. imu_rd_done at cycle U gives ACC_CALC at U+1, with imu_rd_req=0 and acc_start=1 for exactly cycle U+1.
  - ACC_CALC: acc_done at cycle V gives FILTER at V+1, with cmp_filter_en=1 for that one cycle.
  - FILTER: moves to SETTLE on the next cycle.
  - SETTLE: lasts FILTER_LAT cycles, then moves to PUBLISH.
  - PUBLISH: att_valid=1 for one cycle and seq_cnt increments; the next state is IDLE.
  - Latency with FILTER_LAT=1: att_valid rises 3 cycles after the cmp_filter_en pulse.
- Timeout:
  - The timeout counter clears on entry to IMU_RD or ACC_CALC.
  - Timeout fires if the counter reaches TIMEOUT_CYC-1 with no done seen.
  - On timeout: go to IDLE next cycle, imu_rd_req drops, err_cnt increments (saturating), and imu_fault or acc_fault is set.
  - No cmp_filter_en or att_valid is issued for that sequence.
  - If done and the timeout limit occur in the same cycle, done wins.
- Overrun: a tick while state != IDLE increments ovr_cnt (saturating). The tick is dropped, not queued.
- sched_en=0 mid-sequence:
  - From any state, go to IDLE on the next cycle and deassert imu_rd_req.
  - No further pulses are issued.
  - Counters and faults are held.
- Done pulses arriving in any other state are ignored and are not remembered.
- fault_clr clears both faults. If fault_clr and a new fault set occur in the same cycle, the set wins.
- Counter rules: ovr_cnt and err_cnt saturate at 255 and are cleared only by rst. seq_cnt wraps.

Decomposition:
- Shared package/header att_sched_pkg:
  - FSM state encoding: IDLE=0, IMU_RD=1, ACC_CALC=2, FILTER=3, SETTLE=4, PUBLISH=5 (3 bits).
  - Default PERIOD_CYC, TIMEOUT_CYC and FILTER_LAT constants.
  - Counter widths: 16 for seq_cnt, 8 for ovr_cnt and err_cnt.
- One sub-module, att_period_timer:
  - Parameter PERIOD_CYC; ports clk, rst, en, tick.
  - Width is ceil(log2(PERIOD_CYC)).
- FSM, timeout counter, fault flags and statistics counters stay in att_update_sched.

Test Plan:
All scenarios use PERIOD_CYC=20, TIMEOUT_CYC=8, FILTER_LAT=1.
1. Nominal: sched_en=1; imu_rd_done 3 cycles after req; acc_done 2 cycles after acc_start -> one acc_start pulse, one cmp_filter_en pulse, att_valid exactly 3 cycles later, seq_cnt=1. Three periods give seq_cnt=3 and att_valid spacing of 20 cycles.
2. IMU timeout: never assert imu_rd_done -> imu_rd_req high for 8 cycles then low, imu_fault=1, err_cnt=1, no cmp_filter_en. Next tick starts a new sequence.
3. Overrun: delay acc_done 25 cycles (within timeout after TIMEOUT_CYC raised to 30) -> ovr_cnt=1, one att_valid only. ovr_cnt saturation: force 300 overruns -> ovr_cnt=255.
4. Done/timeout collision: acc_done exactly at timeout cycle 7 -> cmp_filter_en is issued, acc_fault=0, err_cnt unchanged.
5. Abort and reset: drop sched_en during ACC_CALC -> IDLE next cycle, no cmp_filter_en, busy=0. Then rst=1 for 1 cycle mid-IMU_RD -> all outputs 0 on the next edge.
6. Fault clear: fault_clr pulse with imu_fault=1 -> 0. fault_clr in the same cycle as a new timeout -> fault remains 1.
